vm_panel_sequencer: RTL and testbench
=====================================

// Module: vm_panel_sequencer
// PURPOSE
//  Front-panel command initiator for the vending machine core (head_module).
//  - Accepts one buffered command per handshake.
//  - Drives the core's mode strobes and operand fields with defined setup, strobe and hold windows.
//  - Reads back the core's two 7-segment outputs and decodes them into a binary result.
//  - Sits between the board-level button/switch logic and head_module.
// PARAMETERS
//  STROBE_CYCLES  1  cycles a mode line is held high per command (>=1)
//  SETTLE_CYCLES  2  cycles after strobe, fields held and modes low, before seg readback (>=1)
// PORTS
//  clk                input   1  system clock, rising edge
//  rst                input   1  synchronous active-high reset
//  cmd_valid          input   1  command request
//  cmd_ready          output  1  high only in IDLE; command accepted on edge with cmd_valid&&cmd_ready
//  cmd_type           input   2  0=customer purchase, 1=owner money collect, 2=owner supply, 3=illegal
//  cmd_product        input   3  product index
//  cmd_money          input   4  customer money inserted
//  cmd_qty            input   4  supply quantity
//  costumer_mode      output  1  to core: customer strobe
//  owner_money_mode   output  1  to core: owner money strobe
//  owner_supply_mode  output  1  to core: owner supply strobe
//  product            output  3  to core: product field
//  costumer_money     output  4  to core: money field
//  quantitiy          output  4  to core: quantity field
//  seg1               input   7  from core: tens digit, active-high {g,f,e,d,c,b,a}
//  seg2               input   7  from core: ones digit, same encoding
//  result_valid       output  1  one-cycle pulse, result fields valid
//  result_value       output  7  tens*10+ones, range 0..99
//  result_err         output  1  qualified by result_valid: illegal cmd or undecodable seg pattern
// BEHAVIOUR
//  Reset values:
//  - All outputs 0 except cmd_ready=1.
//  - FSM to IDLE.
//  Fields:
//  - Fields are registered at acceptance.
//  - Fields hold stable from SETUP through CAPTURE and keep their value in IDLE until the next accept.
//  FSM: IDLE -> SETUP (1 cyc) -> STROBE (STROBE_CYCLES) -> HOLD (SETTLE_CYCLES) -> CAPTURE (1 cyc) -> IDLE.
//  - SETUP: all modes low, fields driven.
//  - STROBE: exactly one mode high, selected by latched cmd_type; the other two low.
//  - HOLD: modes low.
//  - CAPTURE: seg1/seg2 sampled at the closing edge.
//  Latency (acceptance edge = cycle 0):
//  - SETUP in cycle 1; STROBE in cycles 2..1+S.
//  - result_valid and cmd_ready=1 together in cycle 3+S+M; defaults give cycle 6.
//  - Next command is accepted earliest at the edge ending that cycle.
//  Illegal cmd_type=3:
//  - Accepted, no strobe, fields unchanged.
//  - Next cycle result_valid=1, result_err=1, result_value=0.
//  Seg decode:
//  - 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F.
//  - Any other pattern on either digit: result_err=1, result_value=0.
//  - Arithmetic: tens*10 + ones in 7 bits; no overflow possible.
//  Handshake:
//  - cmd_valid while busy is ignored (not queued).
//  - Requester holds cmd_* until accepted.
//  Reset mid-operation:
//  - Next edge forces modes low and the FSM to IDLE.
//  - Drops the pending result; no result_valid.
//  Invariants:
//  - At most one mode high in any cycle.
//  - Never two strobes without at least SETTLE_CYCLES+2 low cycles between them.
// TESTING
//  1. Reset; check: cmd_ready=1, all modes 0, result_valid=0.
//  2. Customer cmd, product=2, money=12; core seg1=06, seg2=5B.
//     -> costumer_mode high in cycle 2 only; product=2, costumer_money=12 stable cycles 1..5;
//        result_valid in cycle 6 with value=12, err=0.
//  3. Owner supply cmd (type=2), product=0, qty=2; cmd_valid held during busy.
//     -> single owner_supply_mode pulse, cmd_ready=0 cycles 1..5, exactly one accept.
//  4. type=3 -> no mode toggles; result_valid in cycle 1 with err=1, value=0.
//  5. Customer cmd with seg2=7'h00 at capture -> result_err=1, result_value=0.
//  6. rst asserted during STROBE -> modes 0 next cycle, cmd_ready=1, no result_valid.
//     Then a new owner-money cmd completes normally.

Source files
------------

// File: rtl/vm_panel_sequencer.sv
// Front-panel command sequencer for the vending machine core: paces one command
// through setup/strobe/hold windows and decodes the core's two 7-segment digits.
module vm_panel_sequencer #(
  parameter int STROBE_CYCLES = 1,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_type,
  input  logic [2:0] cmd_product,
  input  logic [3:0] cmd_money,
  input  logic [3:0] cmd_qty,
  output logic       costumer_mode,
  output logic       owner_money_mode,
  output logic       owner_supply_mode,
  output logic [2:0] product,
  output logic [3:0] costumer_money,
  output logic [3:0] quantitiy,
  input  logic [6:0] seg1,
  input  logic [6:0] seg2,
  output logic       result_valid,
  output logic [6:0] result_value,
  output logic       result_err
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETUP   = 3'd1,
    STROBE  = 3'd2,
    HOLD    = 3'd3,
    CAPTURE = 3'd4
  } state_t;

  localparam logic [7:0] S_LAST = 8'(STROBE_CYCLES - 1);
  localparam logic [7:0] M_LAST = 8'(SETTLE_CYCLES - 1);

  // Returns {pattern_ok, digit}; unknown patterns report not-ok.
  function automatic logic [4:0] seg_decode(input logic [6:0] seg);
    case (seg)
      7'h3F:   seg_decode = {1'b1, 4'd0};
      7'h06:   seg_decode = {1'b1, 4'd1};
      7'h5B:   seg_decode = {1'b1, 4'd2};
      7'h4F:   seg_decode = {1'b1, 4'd3};
      7'h66:   seg_decode = {1'b1, 4'd4};
      7'h6D:   seg_decode = {1'b1, 4'd5};
      7'h7D:   seg_decode = {1'b1, 4'd6};
      7'h07:   seg_decode = {1'b1, 4'd7};
      7'h7F:   seg_decode = {1'b1, 4'd8};
      7'h6F:   seg_decode = {1'b1, 4'd9};
      default: seg_decode = {1'b0, 4'd0};
    endcase
  endfunction

  state_t     state_q;
  logic [7:0] cnt_q;
  logic [1:0] type_q;
  logic       ready_q, rvalid_q, rerr_q;
  logic [6:0] rvalue_q;
  logic       cust_q, omoney_q, osupply_q;
  logic [2:0] prod_q;
  logic [3:0] money_q, qty_q;

  logic [4:0] dec1_s, dec2_s;
  logic [6:0] seg_value_s;
  logic       seg_ok_s;

  always_comb begin
    dec1_s      = seg_decode(seg1);
    dec2_s      = seg_decode(seg2);
    seg_ok_s    = dec1_s[4] & dec2_s[4];
    seg_value_s = ({3'd0, dec1_s[3:0]} * 7'd10) + {3'd0, dec2_s[3:0]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= 8'd0;
      type_q    <= 2'd0;
      ready_q   <= 1'b1;
      rvalid_q  <= 1'b0;
      rerr_q    <= 1'b0;
      rvalue_q  <= 7'd0;
      cust_q    <= 1'b0;
      omoney_q  <= 1'b0;
      osupply_q <= 1'b0;
      prod_q    <= 3'd0;
      money_q   <= 4'd0;
      qty_q     <= 4'd0;
    end else begin
      rvalid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (cmd_valid) begin
            // Illegal commands short-circuit: no strobe, fields left untouched.
            if (cmd_type == 2'd3) begin
              rvalid_q <= 1'b1;
              rerr_q   <= 1'b1;
              rvalue_q <= 7'd0;
            end else begin
              type_q  <= cmd_type;
              prod_q  <= cmd_product;
              money_q <= cmd_money;
              qty_q   <= cmd_qty;
              ready_q <= 1'b0;
              state_q <= SETUP;
            end
          end
        end
        SETUP: begin
          cnt_q     <= 8'd0;
          cust_q    <= (type_q == 2'd0);
          omoney_q  <= (type_q == 2'd1);
          osupply_q <= (type_q == 2'd2);
          state_q   <= STROBE;
        end
        STROBE: begin
          if (cnt_q == S_LAST) begin
            cust_q    <= 1'b0;
            omoney_q  <= 1'b0;
            osupply_q <= 1'b0;
            cnt_q     <= 8'd0;
            state_q   <= HOLD;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        HOLD: begin
          if (cnt_q == M_LAST) begin
            state_q <= CAPTURE;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        CAPTURE: begin
          rvalid_q <= 1'b1;
          rerr_q   <= ~seg_ok_s;
          rvalue_q <= seg_ok_s ? seg_value_s : 7'd0;
          ready_q  <= 1'b1;
          state_q  <= IDLE;
        end
        default: begin
          cust_q    <= 1'b0;
          omoney_q  <= 1'b0;
          osupply_q <= 1'b0;
          ready_q   <= 1'b1;
          state_q   <= IDLE;
        end
      endcase
    end
  end

  assign cmd_ready         = ready_q;
  assign costumer_mode     = cust_q;
  assign owner_money_mode  = omoney_q;
  assign owner_supply_mode = osupply_q;
  assign product           = prod_q;
  assign costumer_money    = money_q;
  assign quantitiy         = qty_q;
  assign result_valid      = rvalid_q;
  assign result_value      = rvalue_q;
  assign result_err        = rerr_q;

endmodule

// File: tb/tb_vm_panel_sequencer.sv
// Self-checking bench for vm_panel_sequencer: directed scenarios plus randomized
// commands checked cycle by cycle against a timeline model of the command windows.
module tb_vm_panel_sequencer;
  localparam int S = 1;
  localparam int M = 2;
  localparam int R = 3 + S + M;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid, cmd_ready;
  logic [1:0] cmd_type;
  logic [2:0] cmd_product;
  logic [3:0] cmd_money, cmd_qty;
  logic       costumer_mode, owner_money_mode, owner_supply_mode;
  logic [2:0] product;
  logic [3:0] costumer_money, quantitiy;
  logic [6:0] seg1, seg2;
  logic       result_valid, result_err;
  logic [6:0] result_value;

  int total = 0;
  int bad   = 0;

  logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                              7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
  logic [2:0] exp_prod;
  logic [3:0] exp_money, exp_qty;

  always #5 clk = ~clk;

  vm_panel_sequencer #(.STROBE_CYCLES(S), .SETTLE_CYCLES(M)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_type(cmd_type), .cmd_product(cmd_product), .cmd_money(cmd_money),
    .cmd_qty(cmd_qty), .costumer_mode(costumer_mode),
    .owner_money_mode(owner_money_mode), .owner_supply_mode(owner_supply_mode),
    .product(product), .costumer_money(costumer_money), .quantitiy(quantitiy),
    .seg1(seg1), .seg2(seg2), .result_valid(result_valid),
    .result_value(result_value), .result_err(result_err)
  );

  // At most one mode line high in any cycle.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      total++;
      if ((32'(costumer_mode) + 32'(owner_money_mode) + 32'(owner_supply_mode)) > 32'd1) begin
        bad++;
        $display("FAIL onehot_modes: got %b%b%b want at most one high",
                 costumer_mode, owner_money_mode, owner_supply_mode);
      end
    end
  end

  // Expected {err, value} from the two digit patterns.
  function automatic logic [7:0] ref_result(input logic [6:0] a, input logic [6:0] b);
    int t = -1;
    int o = -1;
    for (int i = 0; i < 10; i++) begin
      if (seg_tab[i] == a) t = i;
      if (seg_tab[i] == b) o = i;
    end
    if (t < 0 || o < 0) return {1'b1, 7'd0};
    return {1'b0, 7'(t * 10 + o)};
  endfunction

  task automatic run_cmd(input logic [1:0] ty, input logic [2:0] p, input logic [3:0] mo,
                         input logic [3:0] q, input logic [6:0] s1, input logic [6:0] s2,
                         input bit hold, input string tag);
    logic [2:0] onehot;
    logic [4:0] exp_vec, got_vec;
    logic [7:0] r;
    seg1 = s1; seg2 = s2;
    cmd_type = ty; cmd_product = p; cmd_money = mo; cmd_qty = q;
    cmd_valid = 1'b1;
    total++;
    if (cmd_ready !== 1'b1) begin
      bad++;
      $display("FAIL %s_ready_idle: got %b want 1", tag, cmd_ready);
    end
    @(posedge clk); #1;
    if (ty == 2'd3) begin
      cmd_valid = 1'b0;
      total++;
      if ({cmd_ready, costumer_mode, owner_money_mode, owner_supply_mode,
           result_valid, result_err, result_value} !== {1'b1, 3'b000, 1'b1, 1'b1, 7'd0}) begin
        bad++;
        $display("FAIL %s_illegal_result: rdy=%b modes=%b%b%b rv=%b err=%b val=%0d want rdy=1 modes=000 rv=1 err=1 val=0",
                 tag, cmd_ready, costumer_mode, owner_money_mode, owner_supply_mode,
                 result_valid, result_err, result_value);
      end
      total++;
      if ({product, costumer_money, quantitiy} !== {exp_prod, exp_money, exp_qty}) begin
        bad++;
        $display("FAIL %s_illegal_fields: got %0d/%0d/%0d want %0d/%0d/%0d", tag,
                 product, costumer_money, quantitiy, exp_prod, exp_money, exp_qty);
      end
      for (int k = 2; k <= 3; k++) begin
        @(posedge clk); #1;
        total++;
        if ({cmd_ready, costumer_mode, owner_money_mode, owner_supply_mode, result_valid} !== 5'b10000) begin
          bad++;
          $display("FAIL %s_illegal_quiet_c%0d: got %b%b%b%b%b want 10000", tag, k, cmd_ready,
                   costumer_mode, owner_money_mode, owner_supply_mode, result_valid);
        end
      end
      return;
    end
    exp_prod = p; exp_money = mo; exp_qty = q;
    r = ref_result(s1, s2);
    onehot = (ty == 2'd0) ? 3'b100 : (ty == 2'd1) ? 3'b010 : 3'b001;
    for (int k = 1; k <= R; k++) begin
      if (!hold) cmd_valid = 1'b0;
      exp_vec = {(k == R), ((k >= 2 && k <= 1 + S) ? onehot : 3'b000), (k == R)};
      got_vec = {cmd_ready, costumer_mode, owner_money_mode, owner_supply_mode, result_valid};
      total++;
      if (got_vec !== exp_vec) begin
        bad++;
        $display("FAIL %s_timeline_c%0d: got rdy/modes/rv=%b want %b", tag, k, got_vec, exp_vec);
      end
      total++;
      if ({product, costumer_money, quantitiy} !== {exp_prod, exp_money, exp_qty}) begin
        bad++;
        $display("FAIL %s_fields_c%0d: got %0d/%0d/%0d want %0d/%0d/%0d", tag, k,
                 product, costumer_money, quantitiy, exp_prod, exp_money, exp_qty);
      end
      if (k == R) begin
        total++;
        if ({result_err, result_value} !== r) begin
          bad++;
          $display("FAIL %s_result: got err=%b val=%0d want err=%b val=%0d", tag,
                   result_err, result_value, r[7], r[6:0]);
        end
      end else begin
        @(posedge clk); #1;
      end
    end
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    total++;
    if ({cmd_ready, costumer_mode, owner_money_mode, owner_supply_mode, result_valid} !== 5'b10000) begin
      bad++;
      $display("FAIL %s_after_idle: got %b%b%b%b%b want 10000", tag, cmd_ready,
               costumer_mode, owner_money_mode, owner_supply_mode, result_valid);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; cmd_valid = 1'b0; cmd_type = 2'd0; cmd_product = 3'd0;
    cmd_money = 4'd0; cmd_qty = 4'd0; seg1 = 7'h3F; seg2 = 7'h3F;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({cmd_ready, costumer_mode, owner_money_mode, owner_supply_mode, result_valid,
         result_err, result_value, product, costumer_money, quantitiy} !==
        {1'b1, 3'b000, 1'b0, 1'b0, 7'd0, 3'd0, 4'd0, 4'd0}) begin
      bad++;
      $display("FAIL reset_state: rdy=%b modes=%b%b%b rv=%b err=%b val=%0d want rdy=1 rest 0",
               cmd_ready, costumer_mode, owner_money_mode, owner_supply_mode,
               result_valid, result_err, result_value);
    end
    rst = 1'b0;
    exp_prod = 3'd0; exp_money = 4'd0; exp_qty = 4'd0;
  endtask

  task automatic test_reset_mid();
    seg1 = 7'h4F; seg2 = 7'h6D;
    cmd_type = 2'd0; cmd_product = 3'd5; cmd_money = 4'd9; cmd_qty = 4'd1;
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    total++;
    if (costumer_mode !== 1'b1) begin
      bad++;
      $display("FAIL midrst_strobe: got %b want 1", costumer_mode);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    total++;
    if ({cmd_ready, costumer_mode, owner_money_mode, owner_supply_mode, result_valid} !== 5'b10000) begin
      bad++;
      $display("FAIL midrst_after: got %b%b%b%b%b want 10000", cmd_ready,
               costumer_mode, owner_money_mode, owner_supply_mode, result_valid);
    end
    exp_prod = 3'd0; exp_money = 4'd0; exp_qty = 4'd0;
    for (int k = 0; k < R; k++) begin
      total++;
      if (result_valid !== 1'b0 || cmd_ready !== 1'b1) begin
        bad++;
        $display("FAIL midrst_no_result_c%0d: rv=%b rdy=%b want rv=0 rdy=1", k, result_valid, cmd_ready);
      end
      @(posedge clk); #1;
    end
    run_cmd(2'd1, 3'd3, 4'd7, 4'd4, 7'h7F, 7'h07, 1'b0, "midrst_money");
  endtask

  task automatic test_random();
    logic [1:0] ty;
    logic [6:0] s1, s2;
    for (int n = 0; n < 40; n++) begin
      ty = 2'($urandom_range(0, 3));
      s1 = ($urandom_range(0, 4) == 0) ? 7'($urandom_range(0, 127)) : seg_tab[$urandom_range(0, 9)];
      s2 = ($urandom_range(0, 4) == 0) ? 7'($urandom_range(0, 127)) : seg_tab[$urandom_range(0, 9)];
      run_cmd(ty, 3'($urandom), 4'($urandom), 4'($urandom), s1, s2,
              bit'($urandom_range(0, 1)) && (ty != 2'd3), "rand");
    end
  endtask

  initial begin
    test_reset();
    run_cmd(2'd0, 3'd2, 4'd12, 4'd0, 7'h06, 7'h5B, 1'b0, "customer");
    run_cmd(2'd2, 3'd0, 4'd0, 4'd2, 7'h3F, 7'h5B, 1'b1, "supply_held");
    run_cmd(2'd3, 3'd6, 4'd3, 4'd3, 7'h06, 7'h06, 1'b0, "illegal");
    run_cmd(2'd0, 3'd1, 4'd5, 4'd0, 7'h6F, 7'h00, 1'b0, "bad_seg");
    run_cmd(2'd1, 3'd7, 4'd15, 4'd15, 7'h6F, 7'h6F, 1'b0, "max99");
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
